// File: rtl/dram_pkg.sv
// Shared definitions for the data-memory responder: FSM encodings and word/lane constants.
package dram_pkg;

  typedef enum logic {
    DRAM_ST_CLEAR = 1'b0,
    DRAM_ST_RUN   = 1'b1
  } dram_state_t;

  localparam int          LANE_W         = 8;
  localparam int          DATA_W         = 32;
  localparam int          LANES          = DATA_W / LANE_W;
  localparam logic [31:0] DRAM_ZERO_WORD = 32'h0000_0000;

  // Legacy names kept for code that still refers to them.
  localparam logic [31:0] ZeroWord = DRAM_ZERO_WORD;
  localparam logic        Enable   = 1'b1;
  localparam logic        Disable  = 1'b0;

endpackage

// File: rtl/dram_byte_lane.sv
// One 8-bit slice of the data array: synchronous write, registered read.
// A read and a write to the same index in one cycle returns the old contents;
// the top level bypasses fresh write data around this.
module dram_byte_lane
  import dram_pkg::*;
#(
  parameter int DEPTH_LOG2 = 12
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [LANE_W-1:0]     wdata,
  input  logic                  re,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [LANE_W-1:0]     rdata
);

  logic [LANE_W-1:0] mem [0:(1<<DEPTH_LOG2)-1];

  // Array write and registered read port; the read register holds when re is low.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/dram_responder.sv
// Data-memory responder: byte-strobed writes, one-cycle registered word reads,
// zero-fill of the array after reset while the pipeline is held off.
module dram_responder
  import dram_pkg::*;
#(
  parameter int          DEPTH_LOG2     = 12,
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_rd_en,
  input  logic [31:0] mem_rd_addr,
  output logic [31:0] mem_rd_data,
  input  logic [31:0] mem_wr_addr,
  input  logic [31:0] mem_wr_data,
  input  logic [3:0]  mem_wen,
  output logic        hold_flag_o,
  output logic        addr_err_o
);

  // Window size is kept 33 bits wide so a full 4 GiB window does not wrap to zero.
  localparam logic [32:0] WIN_BYTES = 33'd4 << DEPTH_LOG2;

  dram_state_t           state, state_nxt;
  logic [DEPTH_LOG2-1:0] clr_idx, clr_idx_nxt;
  logic                  clearing, running;

  logic [31:0]           rd_off, wr_off;
  logic                  rd_in, wr_in;
  logic [DEPTH_LOG2-1:0] rd_idx, wr_idx;

  logic [LANES-1:0]      lane_we;
  logic [LANE_W-1:0]     lane_q [LANES];

  // Registered read-side control and bypass data.
  logic                  rd_zero_p1;
  logic [LANES-1:0]      byp_p1;
  logic [31:0]           byp_data_p1;
  logic                  err_p1;

  assign rd_off = mem_rd_addr - BASE_ADDR;
  assign wr_off = mem_wr_addr - BASE_ADDR;
  assign rd_in  = {1'b0, rd_off} < WIN_BYTES;
  assign wr_in  = {1'b0, wr_off} < WIN_BYTES;
  assign rd_idx = rd_off[DEPTH_LOG2+1:2];
  assign wr_idx = wr_off[DEPTH_LOG2+1:2];

  // State and clear-index registers; reset restarts the clear from index 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR_ON_RESET ? DRAM_ST_CLEAR : DRAM_ST_RUN;
      clr_idx <= '0;
    end else begin
      state   <= state_nxt;
      clr_idx <= clr_idx_nxt;
    end
  end

  // Next-state logic: walk every index once in CLEAR, then stay in RUN.
  always_comb begin
    state_nxt   = state;
    clr_idx_nxt = clr_idx;
    clearing    = 1'b0;
    running     = 1'b0;
    case (state)
      DRAM_ST_CLEAR: begin
        clearing    = 1'b1;
        clr_idx_nxt = clr_idx + 1'b1;
        if (&clr_idx) begin
          state_nxt = DRAM_ST_RUN;
        end
      end
      DRAM_ST_RUN: begin
        running = 1'b1;
      end
      default: begin
        state_nxt = DRAM_ST_RUN;
      end
    endcase
  end

  assign hold_flag_o = clearing;

  // Four byte lanes; clearing drives every lane write port with zero at clr_idx.
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign lane_we[g] = clearing | (running & mem_wen[g] & wr_in);

    dram_byte_lane #(
      .DEPTH_LOG2(DEPTH_LOG2)
    ) u_lane (
      .clk  (clk),
      .we   (lane_we[g]),
      .waddr(clearing ? clr_idx : wr_idx),
      .wdata(clearing ? DRAM_ZERO_WORD[g*LANE_W +: LANE_W] : mem_wr_data[g*LANE_W +: LANE_W]),
      .re   (running & mem_rd_en),
      .raddr(rd_idx),
      .rdata(lane_q[g])
    );
  end

  // Read control and error pulse: zero-force, per-lane bypass select, window error.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_zero_p1 <= 1'b1;
      byp_p1     <= '0;
      err_p1     <= 1'b0;
    end else begin
      err_p1 <= running & ((mem_rd_en & ~rd_in) | ((|mem_wen) & ~wr_in));
      if (clearing) begin
        rd_zero_p1 <= 1'b1;
        byp_p1     <= '0;
      end else if (mem_rd_en) begin
        rd_zero_p1 <= ~rd_in;
        byp_p1     <= (wr_in && (wr_idx == rd_idx)) ? mem_wen : '0;
      end
    end
  end

  // Bypass data captured alongside each accepted read.
  always_ff @(posedge clk) begin
    if (running & mem_rd_en) begin
      byp_data_p1 <= mem_wr_data;
    end
  end

  // ---- stage p1: output select from registered state ----
  // Per-lane write-first mux on the registered read word.
  always_comb begin
    mem_rd_data = DRAM_ZERO_WORD;
    for (int i = 0; i < LANES; i++) begin
      if (!rd_zero_p1) begin
        mem_rd_data[i*LANE_W +: LANE_W] = byp_p1[i] ? byp_data_p1[i*LANE_W +: LANE_W] : lane_q[i];
      end
    end
  end

  assign addr_err_o = err_p1;

endmodule
